// File: rtl/bw_frame_reader.sv
// bw_frame_reader: read side of the 1-bit black/white frame BRAM.
// Scans the stored image pixel by pixel, presents each pixel to the plotter
// over a rising-edge ready handshake, and freezes the BRAM write side while
// a scan is in progress.
// Optional feature macro: SERPENTINE_EN (odd rows scanned right to left).
module bw_frame_reader #(
  parameter int unsigned IMG_W    = 80,
  parameter int unsigned IMG_H    = 106,
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned READ_LAT = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic              ready_next_pixel_in,
  input  logic              bram_data_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic              pixel_value_out,
  output logic              pixel_valid_out,
  output logic [6:0]        hcount_out,
  output logic [6:0]        vcount_out,
  output logic              busy_out,
  output logic              freeze_out,
  output logic              frame_done_out
);

  localparam int unsigned POS_W = 7;
  localparam int unsigned CNT_W = $clog2(READ_LAT + 2);

`ifdef SERPENTINE_EN
  localparam bit SERP = 1'b1;
`else
  localparam bit SERP = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_PRESENT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            state_q;
  logic [POS_W-1:0]  h_q, v_q, h_d, v_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d, addr_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              prev_ready_q;
  logic              consume_c, last_c;

  logic [ADDR_W-1:0] addr_q;
  logic              pix_q, valid_q, busy_q, done_q;
  logic [POS_W-1:0]  hcnt_q, vcnt_q;

  // Physical column of logical index h; odd rows mirror when serpentine.
  function automatic logic [POS_W-1:0] phys_col(input logic [POS_W-1:0] h,
                                                input logic             odd);
    phys_col = (SERP && odd) ? (POS_W'(IMG_W - 1) - h) : h;
  endfunction

  // Rising-edge consume detect and end-of-frame detect.
  always_comb begin
    consume_c = ready_next_pixel_in & ~prev_ready_q;
    last_c    = (h_q == POS_W'(IMG_W - 1)) && (v_q == POS_W'(IMG_H - 1));
  end

  // Next scan position; row base is accumulated rather than multiplied.
  always_comb begin
    h_d        = h_q;
    v_d        = v_q;
    row_base_d = row_base_q;
    if (h_q < POS_W'(IMG_W - 1)) begin
      h_d = h_q + POS_W'(1);
    end else begin
      h_d        = '0;
      v_d        = v_q + POS_W'(1);
      row_base_d = row_base_q + ADDR_W'(IMG_W);
    end
    addr_d = row_base_d + ADDR_W'(phys_col(h_d, v_d[0]));
  end

  // Scan FSM with registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      h_q          <= '0;
      v_q          <= '0;
      row_base_q   <= '0;
      cnt_q        <= '0;
      prev_ready_q <= 1'b0;
      addr_q       <= '0;
      pix_q        <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
    end else begin
      prev_ready_q <= ready_next_pixel_in;
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_in) begin
            h_q        <= '0;
            v_q        <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (cnt_q == CNT_W'(READ_LAT)) begin
            pix_q   <= bram_data_in;
            valid_q <= 1'b1;
            hcnt_q  <= phys_col(h_q, v_q[0]);
            vcnt_q  <= v_q;
            state_q <= S_PRESENT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_PRESENT: begin
          if (consume_c) begin
            valid_q <= 1'b0;
            if (last_c) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              h_q        <= h_d;
              v_q        <= v_d;
              row_base_q <= row_base_d;
              addr_q     <= addr_d;
              cnt_q      <= '0;
              state_q    <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Output port mapping; freeze tracks busy exactly.
  always_comb begin
    addr_out        = addr_q;
    pixel_value_out = pix_q;
    pixel_valid_out = valid_q;
    hcount_out      = hcnt_q;
    vcount_out      = vcnt_q;
    busy_out        = busy_q;
    freeze_out      = busy_q;
    frame_done_out  = done_q;
  end

endmodule
